// File: rtl/aes_half_word_unpacker_if.sv
// Bundle between the crypto-clock glue / AES core and the half-word unpacker.
// The slave modport is the unpacker; the master modport is everything around it.
interface aes_half_word_unpacker_if #(
  parameter int LAT_WIDTH = 16
);
  logic                 load;
  logic                 start;
  logic                 mode;
  logic [63:0]          key_half;
  logic [63:0]          data_half;
  logic                 core_start;
  logic                 core_mode;
  logic [127:0]         core_key;
  logic [127:0]         core_data;
  logic                 core_valid;
  logic [127:0]         core_result;
  logic [127:0]         data_out;
  logic                 done;
  logic [LAT_WIDTH-1:0] lat_count;
  logic                 err_seq;
  logic                 err_timeout;

  modport slave (
    input  load, start, mode, key_half, data_half, core_valid, core_result,
    output core_start, core_mode, core_key, core_data, data_out, done,
           lat_count, err_seq, err_timeout
  );

  modport master (
    output load, start, mode, key_half, data_half, core_valid, core_result,
    input  core_start, core_mode, core_key, core_data, data_out, done,
           lat_count, err_seq, err_timeout
  );
endinterface

// File: rtl/aes_half_word_unpacker.sv
// Reassembles 64-bit key/data halves into 128-bit words, launches the AES core,
// returns its result and measures core latency with a timeout guard.
module aes_half_word_unpacker #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LAT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  aes_half_word_unpacker_if.slave bus
);
  localparam int EW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [EW-1:0]        ELAPSED_LAST = EW'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_WIDTH-1:0] LAT_MAX      = '1;

  typedef enum logic [1:0] {IDLE, LOW, ISSUE, BUSY} state_t;

  state_t                state;
  logic                  core_start;
  logic                  core_mode;
  logic                  done;
  logic [127:0]          data_out;
  logic [LAT_WIDTH-1:0]  lat_count;
  logic [LAT_WIDTH-1:0]  lat_cnt;
  logic [EW-1:0]         elapsed;
  logic                  err_seq;
  logic                  err_timeout;
  logic [1:0]            cap_en;

  // Low half is (re)captured on any load in IDLE/LOW; high half only on a clean start.
  always_comb begin
    cap_en = 2'b00;
    if ((state == IDLE || state == LOW) && bus.load) begin
      cap_en[0] = 1'b1;
    end else if (state == LOW && bus.start) begin
      cap_en[1] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      logic [63:0] key_q;
      logic [63:0] data_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          key_q  <= '0;
          data_q <= '0;
        end else if (cap_en[gi]) begin
          key_q  <= bus.key_half;
          data_q <= bus.data_half;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      core_start  <= 1'b0;
      core_mode   <= 1'b0;
      done        <= 1'b1;
      data_out    <= '0;
      lat_count   <= '0;
      lat_cnt     <= '0;
      elapsed     <= '0;
      err_seq     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            state <= LOW;
          end else if (bus.start) begin
            err_seq <= 1'b1;
          end
        end
        LOW: begin
          if (bus.start && !bus.load) begin
            core_mode  <= bus.mode;
            done       <= 1'b0;
            core_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // The core_start cycle itself counts as the first cycle of latency.
          elapsed <= EW'(1);
          lat_cnt <= LAT_WIDTH'(1);
          state   <= BUSY;
        end
        BUSY: begin
          if (bus.core_valid) begin
            data_out  <= bus.core_result;
            lat_count <= lat_cnt;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (elapsed == ELAPSED_LAST) begin
            err_timeout <= 1'b1;
            data_out    <= '0;
            done        <= 1'b1;
            state       <= IDLE;
          end else begin
            elapsed <= elapsed + 1'b1;
            if (lat_cnt != LAT_MAX) begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.core_start  = core_start;
  assign bus.core_mode   = core_mode;
  assign bus.core_key    = {g_half[1].key_q, g_half[0].key_q};
  assign bus.core_data   = {g_half[1].data_q, g_half[0].data_q};
  assign bus.data_out    = data_out;
  assign bus.done        = done;
  assign bus.lat_count   = lat_count;
  assign bus.err_seq     = err_seq;
  assign bus.err_timeout = err_timeout;
endmodule

// File: tb/tb_aes_half_word_unpacker.sv
// Randomized scoreboard bench: stimulus pushes expected launches/results, a monitor
// process compares them whenever core_start pulses or done rises.
module tb_aes_half_word_unpacker;
  localparam int TO = 16;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  aes_half_word_unpacker_if #(.LAT_WIDTH(LW)) bus ();

  aes_half_word_unpacker #(.TIMEOUT_CYCLES(TO), .LAT_WIDTH(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic         mode;
  } issue_t;

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] result;
    logic [LW-1:0] lat;
    logic         err_to;
    logic         err_sq;
  } result_t;

  issue_t  issue_q[$];
  result_t result_q[$];
  int checks = 0;
  int passes = 0;

  logic [LW-1:0] m_lat = '0;
  logic          m_err_to = 1'b0;
  logic          m_err_seq = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares launches and completions against the scoreboard queues.
  logic    prev_done = 1'b1;
  issue_t  mi;
  result_t mr;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.core_start) begin
        if (issue_q.size() == 0) check("spurious core_start", 1, 0);
        else begin
          mi = issue_q.pop_front();
          check("core_key", bus.core_key, mi.key);
          check("core_data", bus.core_data, mi.data);
          check("core_mode", 128'(bus.core_mode), 128'(mi.mode));
        end
      end
      if (bus.done && !prev_done) begin
        if (result_q.size() == 0) check("spurious done", 1, 0);
        else begin
          mr = result_q.pop_front();
          check("data_out", bus.data_out, mr.result);
          check("lat_count", 128'(bus.lat_count), 128'(mr.lat));
          check("err_timeout", 128'(bus.err_timeout), 128'(mr.err_to));
          check("err_seq", 128'(bus.err_seq), 128'(mr.err_sq));
          check("core_key stable", bus.core_key, mr.key);
          check("core_data stable", bus.core_data, mr.data);
        end
      end
    end
    prev_done = bus.done;
  end

  task automatic idle_inputs();
    bus.load = 1'b0;
    bus.start = 1'b0;
    bus.core_valid = 1'b0;
  endtask

  // Drives 1..nloads low-half cycles (last one carries kl/dl) and the start cycle;
  // returns just after the edge that should raise core_start.
  task automatic issue(input int nloads, input logic [63:0] kl, input logic [63:0] dl,
                       input logic [63:0] kh, input logic [63:0] dh, input logic m,
                       output logic [127:0] key, output logic [127:0] data);
    for (int i = 0; i < nloads; i++) begin
      @(posedge clk); #1;
      bus.load = 1'b1;
      bus.start = ($urandom_range(0, 3) == 0);
      bus.key_half  = (i == nloads - 1) ? kl : rand64();
      bus.data_half = (i == nloads - 1) ? dl : rand64();
    end
    @(posedge clk); #1;
    bus.load = 1'b0;
    bus.start = 1'b1;
    bus.mode = m;
    bus.key_half = kh;
    bus.data_half = dh;
    key = {kh, kl};
    data = {dh, dl};
    issue_q.push_back('{key: key, data: data, mode: m});
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.key_half = rand64();
    bus.data_half = rand64();
  endtask

  task automatic run_op(input int nloads, input logic [63:0] kl, input logic [63:0] kh,
                        input int lat, input logic [127:0] res, input bit noise);
    logic [127:0] key, data, exp_res;
    int w;
    issue(nloads, kl, rand64(), kh, rand64(), 1'($urandom), key, data);
    if (lat <= TO - 1) begin
      m_lat = LW'(lat);
      exp_res = res;
    end else begin
      m_err_to = 1'b1;
      exp_res = '0;
    end
    result_q.push_back('{key: key, data: data, result: exp_res, lat: m_lat,
                         err_to: m_err_to, err_sq: m_err_seq});
    for (int j = 1; j <= lat; j++) begin
      @(posedge clk); #1;
      if (noise && j < TO && j < lat) begin
        bus.load = 1'($urandom);
        bus.start = 1'($urandom);
        bus.key_half = rand64();
        bus.data_half = rand64();
      end else begin
        bus.load = 1'b0;
        bus.start = 1'b0;
      end
      if (j == TO - 1 && lat > TO - 1) check("done low before timeout", 128'(bus.done), 0);
      if (j == TO && lat > TO - 1) check("done at timeout cycle", 128'(bus.done), 1);
      if (j == lat && lat <= TO - 1) check("done low in flight", 128'(bus.done), 0);
    end
    bus.core_valid = 1'b1;
    bus.core_result = res;
    @(posedge clk); #1;
    bus.core_valid = 1'b0;
    bus.core_result = rand128();
    w = 0;
    while (!bus.done && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.done) check("done wait expired", 0, 1);
  endtask

  task automatic stray_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m_err_seq = 1'b1;
    check("err_seq after stray start", 128'(bus.err_seq), 1);
    @(posedge clk); #1;
    check("done after stray start", 128'(bus.done), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " done"}, 128'(bus.done), 1);
    check({tag, " core_start"}, 128'(bus.core_start), 0);
    check({tag, " data_out"}, bus.data_out, 0);
    check({tag, " lat_count"}, 128'(bus.lat_count), 0);
    check({tag, " err_seq"}, 128'(bus.err_seq), 0);
    check({tag, " err_timeout"}, 128'(bus.err_timeout), 0);
    check({tag, " core_key"}, bus.core_key, 0);
  endtask

  initial begin
    logic [127:0] key, data;
    idle_inputs();
    bus.mode = 1'b0;
    bus.key_half = '0;
    bus.data_half = '0;
    bus.core_result = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    stray_start();
    run_op(1, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 11,
           128'h69C4E0D86A7B0430D8CDB78070B4C55A, 1'b0);
    $display("op vector: data_out=%h lat=%0d", bus.data_out, bus.lat_count);
    run_op(3, rand64(), rand64(), 5, rand128(), 1'b0);
    run_op(1, rand64(), rand64(), TO + 1, rand128(), 1'b0);
    run_op(2, rand64(), rand64(), 1, rand128(), 1'b1);
    run_op(1, rand64(), rand64(), TO - 1, rand128(), 1'b1);

    // Asynchronous reset in the middle of a BUSY operation.
    issue(2, rand64(), rand64(), rand64(), rand64(), 1'b1, key, data);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_reset_values("mid-busy reset");
    m_lat = '0;
    m_err_to = 1'b0;
    m_err_seq = 1'b0;
    idle_inputs();
    @(posedge clk); #1 reset_n = 1'b1;
    $display("mid-busy reset applied, key was %h", key);
    run_op(1, rand64(), rand64(), 7, rand128(), 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) stray_start();
      run_op($urandom_range(1, 3), rand64(), rand64(), $urandom_range(1, TO + 2),
             rand128(), 1'($urandom));
      $display("op %0d: data_out=%h lat=%0d err_to=%0d", n, bus.data_out, bus.lat_count,
               bus.err_timeout);
    end

    repeat (3) @(posedge clk);
    check("launches left unmatched", 128'(issue_q.size()), 0);
    check("results left unmatched", 128'(result_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
